fifo_stream_out: RTL and testbench

//  Read-side adapter placed directly downstream of the single-clock fifo.

---
 rtl/fifo_stream_out.sv | 97 +++++++++
 tb/tb_fifo_stream_out.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Read-side adapter for the single-clock fifo: turns rd_en/empty with one-cycle
// read latency into a first-word-fall-through valid/ready stream (head + skid).
module fifo_stream_out #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            count_o
);

  // Stream handshake: a word transfers on every clk edge where m_valid_o and
  // m_ready_i are both high; m_data_o holds steady while valid waits on ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                r_state;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic [1:0]            w_cnt;
  logic                  w_pop;
  logic [2:0]            w_occ;

  assign w_cnt = r_state;
  assign w_pop = r_valid & m_ready_i;

  // Words held plus the one in flight, minus the one leaving this cycle.
  assign w_occ = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Gated by rst_n so the strobe drops the moment reset is asserted.
  assign fifo_rd_en_o = rst_n & ~fifo_empty_i & ~flush_i & (w_occ < 3'd2);

  assign m_valid_o = r_valid;
  assign m_data_o  = r_head;
  assign count_o   = w_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_inflight <= fifo_rd_en_o;
      if (flush_i) begin
        r_state <= ST_EMPTY;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (r_inflight) begin
              r_head  <= fifo_rd_data_i;
              r_state <= ST_ONE;
              r_valid <= 1'b1;
            end
          end
          ST_ONE: begin
            if (r_inflight && !w_pop) begin
              r_skid  <= fifo_rd_data_i;
              r_state <= ST_TWO;
            end else if (r_inflight && w_pop) begin
              r_head  <= fifo_rd_data_i;
            end else if (w_pop) begin
              r_state <= ST_EMPTY;
              r_valid <= 1'b0;
            end
          end
          ST_TWO: begin
            // No read can be in flight here, so only a pop moves the skid up.
            if (w_pop) begin
              r_head  <= r_skid;
              r_state <= ST_ONE;
            end
          end
          default: begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural fifo with one-cycle read latency,
// directed scenarios, and a monitor that pops an expected-word queue on each transfer.
module tb_fifo_stream_out;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_rd_data_i = '0;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b0;
  logic [1:0]    count_o;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_push = 0;
  int            n_pop  = 0;
  int            n_drop = 0;
  int            checks = 0;
  int            errors = 0;
  int            rd_base;

  always #5 clk = ~clk;

  fifo_stream_out #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .fifo_rd_data_i(fifo_rd_data_i),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_ready_i     (m_ready_i),
    .count_o       (count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural fifo: data appears on fifo_rd_data_i one cycle after rd_en.
  assign fifo_empty_i = (n_push == n_pop + n_drop);

  always @(posedge clk) begin
    if (rst_n && fifo_rd_en_o) begin
      chk("rd_while_empty", fifo_empty_i, 1'b0);
      if (!fifo_empty_i) begin
        fifo_rd_data_i <= fifo_q[n_pop + n_drop];
        n_pop          <= n_pop + 1;
      end
    end
  end

  // Monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_range", (count_o <= 2'd2), 1'b1);
      chk("valid_vs_count", m_valid_o, (count_o != 2'd0));
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data_o);
        end else begin
          chk("stream_data", m_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    n_push++;
  endtask

  task automatic drop_exp(input int n);
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      next_cyc();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset with A,B,C already in the fifo, sink ready.
    m_ready_i = 1'b1;
    push_word(32'hA0A0_0001);
    push_word(32'hB0B0_0002);
    push_word(32'hC0C0_0003);
    next_cyc();
    at_neg();
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_data", m_data_o, 32'h0);
    chk("rst_count", count_o, 2'd0);
    chk("rst_rd_en", fifo_rd_en_o, 1'b0);
    next_cyc();
    rst_n = 1'b1;
    at_neg();
    chk("t1_c0_rd", fifo_rd_en_o, 1'b1);
    chk("t1_c0_valid", m_valid_o, 1'b0);
    next_cyc();
    at_neg();
    chk("t1_c1_rd", fifo_rd_en_o, 1'b1);
    chk("t1_c1_valid", m_valid_o, 1'b0);
    next_cyc();
    at_neg();
    chk("t1_c2_rd", fifo_rd_en_o, 1'b1);
    chk("t1_c2_valid", m_valid_o, 1'b1);
    chk("t1_c2_data", m_data_o, 32'hA0A0_0001);
    chk("t1_c2_count", count_o, 2'd1);
    next_cyc();
    at_neg();
    chk("t4_landpop_data", m_data_o, 32'hB0B0_0002);
    chk("t4_landpop_count", count_o, 2'd1);
    chk("t1_c3_rd", fifo_rd_en_o, 1'b0);
    next_cyc();
    at_neg();
    chk("t1_c4_data", m_data_o, 32'hC0C0_0003);
    chk("t1_c4_count", count_o, 2'd1);
    next_cyc();
    at_neg();
    chk("t1_c5_valid", m_valid_o, 1'b0);
    chk("t1_drained", exp_q.size(), 0);

    // Backpressure: five words, sink stalled.
    next_cyc();
    m_ready_i = 1'b0;
    rd_base = n_pop;
    for (int i = 0; i < 5; i++) push_word(32'hD0 + i);
    repeat (6) next_cyc();
    at_neg();
    chk("t2_rd_pulses", n_pop - rd_base, 2);
    chk("t2_count", count_o, 2'd2);
    chk("t2_head", m_data_o, 32'hD0);
    chk("t2_valid", m_valid_o, 1'b1);
    next_cyc();
    m_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t2_no_gap", m_valid_o, 1'b1);
      next_cyc();
    end
    at_neg();
    chk("t2_end_valid", m_valid_o, 1'b0);
    chk("t2_drained", exp_q.size(), 0);

    // Toggling ready against a continuous source.
    next_cyc();
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    for (int i = 0; i < 40; i++) begin
      m_ready_i = (i % 2 == 0);
      next_cyc();
    end
    m_ready_i = 1'b1;
    wait_drain("t3_drain");
    at_neg();
    chk("t3_end_valid", m_valid_o, 1'b0);

    // Flushes: with a word landing, with head + landing word, and in TWO.
    next_cyc();
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h50 + i);
    next_cyc();
    flush_i = 1'b1;
    at_neg();
    chk("t5_flush_no_rd", fifo_rd_en_o, 1'b0);
    next_cyc();
    flush_i = 1'b0;
    drop_exp(1);
    at_neg();
    chk("t5a_valid", m_valid_o, 1'b0);
    chk("t5a_count", count_o, 2'd0);
    chk("t5a_rd_resume", fifo_rd_en_o, 1'b1);
    next_cyc();
    next_cyc();
    flush_i = 1'b1;
    at_neg();
    chk("t5b_pre_count", count_o, 2'd1);
    chk("t5b_pre_head", m_data_o, 32'h51);
    next_cyc();
    flush_i = 1'b0;
    drop_exp(2);
    at_neg();
    chk("t5b_valid", m_valid_o, 1'b0);
    chk("t5b_count", count_o, 2'd0);
    repeat (5) next_cyc();
    at_neg();
    chk("t5c_pre_count", count_o, 2'd2);
    chk("t5c_pre_head", m_data_o, 32'h53);
    next_cyc();
    flush_i = 1'b1;
    next_cyc();
    flush_i = 1'b0;
    drop_exp(2);
    at_neg();
    chk("t5c_valid", m_valid_o, 1'b0);
    chk("t5c_count", count_o, 2'd0);
    next_cyc();
    m_ready_i = 1'b1;
    wait_drain("t5_drain");

    // Asynchronous reset mid-stream, then recovery.
    next_cyc();
    for (int i = 0; i < 6; i++) push_word(32'h60 + i);
    repeat (3) next_cyc();
    #7;
    rst_n = 1'b0;
    n_drop = n_push - n_pop;
    exp_q.delete();
    #1;
    chk("t6_valid", m_valid_o, 1'b0);
    chk("t6_rd_en", fifo_rd_en_o, 1'b0);
    chk("t6_count", count_o, 2'd0);
    chk("t6_data", m_data_o, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    push_word(32'h70);
    push_word(32'h71);
    wait_drain("t6_recover");

    repeat (2) next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
